// File: rtl/exp4_receptor_medida.sv
// exp4_receptor_medida
// Receives 4-character ASCII distance frames ("ddd#") from a UART receiver,
// validates them and assembles the three digits into a 12-bit BCD value.
// Reports valid frames, discarded frames and a wrapping valid-frame count.
// After a bad character it resynchronises on the next '#'. An inter-character
// timeout drops a frame that stalls partway through.

module exp4_receptor_medida #(
  parameter int TIMEOUT_CICLOS = 5_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic [6:0]  dado_rx,
  input  logic        pronto_rx,
  input  logic        erro_rx,
  output logic [11:0] medida,
  output logic        medida_valida,
  output logic        erro_quadro,
  output logic [7:0]  contagem_quadros,
  output logic [3:0]  db_estado
);

  // Wide enough to hold TIMEOUT_CICLOS itself; only values up to
  // TIMEOUT_CICLOS-1 are ever reached.
  localparam int                CNT_W   = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CNT_W-1:0]  CNT_FIM = CNT_W'(TIMEOUT_CICLOS - 1);

  // The codes are also the debug output, so the encoding is fixed.
  typedef enum logic [3:0] {
    INICIAL           = 4'b0000,
    ESPERA_CENTENA    = 4'b0001,
    ESPERA_DEZENA     = 4'b0010,
    ESPERA_UNIDADE    = 4'b0011,
    ESPERA_TERMINADOR = 4'b0100,
    VALIDA            = 4'b0101,
    SINCRONIZA        = 4'b0110,
    ERRO_BYTE         = 4'b0111,
    ERRO_TEMPO        = 4'b1000
  } estado_t;

  estado_t          estado;
  estado_t          estado_prox;
  logic [CNT_W-1:0] contador;
  logic [3:0]       centena;
  logic [3:0]       dezena;
  logic [3:0]       unidade;

  logic eh_digito;
  logic eh_terminador;
  logic conta_tempo;
  logic tempo_esgotado;

  // A character with a parity or stop error is invalid whatever its code.
  assign eh_digito     = !erro_rx && (dado_rx[6:4] == 3'b011) && (dado_rx[3:0] <= 4'd9);
  assign eh_terminador = !erro_rx && (dado_rx == 7'h23);

  // The idle timer runs only mid-frame and while hunting for a terminator.
  assign conta_tempo = (estado == ESPERA_DEZENA)     ||
                       (estado == ESPERA_UNIDADE)    ||
                       (estado == ESPERA_TERMINADOR) ||
                       (estado == SINCRONIZA);

  // A strobe in the expiry cycle wins, so the timeout is masked by pronto_rx.
  assign tempo_esgotado = conta_tempo && (contador == CNT_FIM) && !pronto_rx;

  assign db_estado = estado;

  // Next-state decision from the current state, character class and timer.
  always_comb begin
    // NOTE: assign a default before the case so that every path drives
    // estado_prox; a missing branch would otherwise infer a latch.
    estado_prox = estado;
    unique case (estado)
      INICIAL: begin
        estado_prox = ESPERA_CENTENA;
      end
      ESPERA_CENTENA: begin
        // A stray '#' is tolerated here: it is what a resynchronised
        // link naturally sends between frames.
        if (pronto_rx) begin
          if (eh_digito)           estado_prox = ESPERA_DEZENA;
          else if (!eh_terminador) estado_prox = ERRO_BYTE;
        end
      end
      ESPERA_DEZENA: begin
        if (pronto_rx)           estado_prox = eh_digito ? ESPERA_UNIDADE : ERRO_BYTE;
        else if (tempo_esgotado) estado_prox = ERRO_TEMPO;
      end
      ESPERA_UNIDADE: begin
        if (pronto_rx)           estado_prox = eh_digito ? ESPERA_TERMINADOR : ERRO_BYTE;
        else if (tempo_esgotado) estado_prox = ERRO_TEMPO;
      end
      ESPERA_TERMINADOR: begin
        if (pronto_rx)           estado_prox = eh_terminador ? VALIDA : ERRO_BYTE;
        else if (tempo_esgotado) estado_prox = ERRO_TEMPO;
      end
      VALIDA: begin
        estado_prox = ESPERA_CENTENA;
      end
      SINCRONIZA: begin
        // A silent link also counts as resynchronised, without a new error.
        if (pronto_rx && eh_terminador) estado_prox = ESPERA_CENTENA;
        else if (tempo_esgotado)        estado_prox = ESPERA_CENTENA;
      end
      ERRO_BYTE: begin
        estado_prox = SINCRONIZA;
      end
      ERRO_TEMPO: begin
        estado_prox = ESPERA_CENTENA;
      end
      default: begin
        estado_prox = INICIAL;
      end
    endcase
    // Disabling overrides every other transition and drops any partial frame.
    if (!ligar) estado_prox = INICIAL;
  end

  // State, registered Moore outputs, idle timer, digit latches and frame count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado           <= INICIAL;
      medida_valida    <= 1'b0;
      erro_quadro      <= 1'b0;
      contador         <= '0;
      centena          <= 4'd0;
      dezena           <= 4'd0;
      unidade          <= 4'd0;
      medida           <= 12'h000;
      contagem_quadros <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values of the others.
      estado        <= estado_prox;
      // Decoding from the next state makes these flops equal to a decode
      // of the state register, without a combinational output path.
      medida_valida <= (estado_prox == VALIDA);
      erro_quadro   <= (estado_prox == ERRO_BYTE) || (estado_prox == ERRO_TEMPO);

      if ((estado_prox != estado) || pronto_rx || !conta_tempo)
        contador <= '0;
      else
        contador <= contador + CNT_W'(1);

      // Digits are latched only when the frame really advances, so a digit
      // arriving as ligar drops cannot leave a stale partial value behind.
      if (estado == ESPERA_CENTENA && estado_prox == ESPERA_DEZENA)
        centena <= dado_rx[3:0];
      if (estado == ESPERA_DEZENA && estado_prox == ESPERA_UNIDADE)
        dezena <= dado_rx[3:0];
      if (estado == ESPERA_UNIDADE && estado_prox == ESPERA_TERMINADOR)
        unidade <= dado_rx[3:0];

      // medida changes only when a complete frame is accepted; ligar=0
      // leaves it alone.
      if (estado_prox == VALIDA && estado != VALIDA)
        medida <= {centena, dezena, unidade};

      // The count moves on the edge leaving valida and wraps naturally.
      if (estado == VALIDA)
        contagem_quadros <= contagem_quadros + 8'd1;
    end
  end

endmodule

// File: tb/tb_exp4_receptor_medida.sv
// Testbench for exp4_receptor_medida.
// A frame-level model (mode, collected-digit queue, one-cycle event, idle
// count) predicts every output each cycle. Directed literal checks at the
// interesting cycles pin the model itself.

module tb_exp4_receptor_medida;

  localparam int TIMEOUT = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        ligar;
  logic [6:0]  dado_rx;
  logic        pronto_rx;
  logic        erro_rx;
  logic [11:0] medida;
  logic        medida_valida;
  logic        erro_quadro;
  logic [7:0]  contagem_quadros;
  logic [3:0]  db_estado;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  exp4_receptor_medida #(.TIMEOUT_CICLOS(TIMEOUT)) dut (
    .clock            (clock),
    .reset            (reset),
    .ligar            (ligar),
    .dado_rx          (dado_rx),
    .pronto_rx        (pronto_rx),
    .erro_rx          (erro_rx),
    .medida           (medida),
    .medida_valida    (medida_valida),
    .erro_quadro      (erro_quadro),
    .contagem_quadros (contagem_quadros),
    .db_estado        (db_estado)
  );

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    tests++;
    if (atual !== esperado) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef enum {M_OFF, M_COLLECT, M_SYNC} mmode_t;
  typedef enum {EV_NONE, EV_VALID, EV_ERR_BYTE, EV_ERR_TIME} mev_t;

  mmode_t      m_mode   = M_OFF;
  mev_t        m_ev     = EV_NONE;
  int          m_digits[$];
  int          m_idle   = 0;
  logic [11:0] m_medida = 12'h000;
  int          m_count  = 0;

  function automatic logic [3:0] exp_estado();
    case (m_ev)
      EV_VALID:    return 4'd5;
      EV_ERR_BYTE: return 4'd7;
      EV_ERR_TIME: return 4'd8;
      default: begin
        if (m_mode == M_OFF)  return 4'd0;
        if (m_mode == M_SYNC) return 4'd6;
        return 4'(1 + m_digits.size());
      end
    endcase
  endfunction

  task automatic frame_error();
    m_digits.delete();
    m_ev   = EV_ERR_BYTE;
    m_mode = M_SYNC;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_step();
    bit is_dig, is_term;
    int n, c;
    if (reset) begin
      m_mode = M_OFF; m_ev = EV_NONE; m_digits.delete();
      m_idle = 0; m_medida = 12'h000; m_count = 0;
      return;
    end
    if (m_ev == EV_VALID) m_count = (m_count + 1) % 256;
    if (!ligar) begin
      m_mode = M_OFF; m_digits.delete(); m_idle = 0; m_ev = EV_NONE;
      return;
    end
    if (m_ev != EV_NONE) begin
      m_ev = EV_NONE; m_idle = 0;
      return;
    end
    if (m_mode == M_OFF) begin
      m_mode = M_COLLECT; m_digits.delete(); m_idle = 0;
      return;
    end
    c       = int'(dado_rx);
    is_dig  = !erro_rx && c >= 48 && c <= 57;
    is_term = !erro_rx && c == 35;
    n       = m_digits.size();
    if (pronto_rx) begin
      m_idle = 0;
      if (m_mode == M_SYNC) begin
        if (is_term) m_mode = M_COLLECT;
      end else if (n < 3) begin
        if (is_dig) m_digits.push_back(c - 48);
        else if (!(is_term && n == 0)) frame_error();
      end else if (is_term) begin
        m_medida = 12'(m_digits[0] * 256 + m_digits[1] * 16 + m_digits[2]);
        m_digits.delete();
        m_ev = EV_VALID;
      end else begin
        frame_error();
      end
    end else if (m_mode == M_SYNC || n > 0) begin
      if (m_idle == TIMEOUT - 1) begin
        m_idle = 0;
        if (m_mode == M_SYNC) m_mode = M_COLLECT;
        else begin
          m_digits.delete();
          m_ev = EV_ERR_TIME;
        end
      end else begin
        m_idle++;
      end
    end else begin
      m_idle = 0;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Compare every output against the model mid-cycle.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      check("m_medida",    medida,           m_medida);
      check("m_valida",    medida_valida,    m_ev == EV_VALID);
      check("m_erro",      erro_quadro,      m_ev == EV_ERR_BYTE || m_ev == EV_ERR_TIME);
      check("m_contagem",  contagem_quadros, m_count);
      check("m_estado",    db_estado,        exp_estado());
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic gap(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Strobe one character for one cycle; returns mid-cycle after the edge
  // that consumed it.
  task automatic send_char(input byte c, input logic e);
    @(negedge clock);
    dado_rx   = c[6:0];
    erro_rx   = e;
    pronto_rx = 1'b1;
    @(negedge clock);
    pronto_rx = 1'b0;
    erro_rx   = 1'b0;
  endtask

  task automatic send_digits(input byte h, input byte t, input byte u);
    send_char(h, 1'b0); gap(2);
    send_char(t, 1'b0); gap(2);
    send_char(u, 1'b0); gap(2);
  endtask

  task automatic send_frame(input byte h, input byte t, input byte u);
    send_digits(h, t, u);
    send_char("#", 1'b0);
    gap(3);
  endtask

  initial begin
    reset = 1'b1; ligar = 1'b0; dado_rx = 7'h00; pronto_rx = 1'b0; erro_rx = 1'b0;
    gap(2);
    check("rst_medida",   medida,           12'h000);
    check("rst_valida",   medida_valida,    1'b0);
    check("rst_erro",     erro_quadro,      1'b0);
    check("rst_contagem", contagem_quadros, 8'd0);
    check("rst_estado",   db_estado,        4'd0);
    reset = 1'b0;
    gap(1);
    ligar = 1'b1;
    gap(2);
    check("ligar_estado", db_estado, 4'd1);

    // Basic frame "123#".
    send_digits("1", "2", "3");
    send_char("#", 1'b0);
    check("f123_valida",   medida_valida, 1'b1);
    check("f123_medida",   medida,        12'h123);
    check("f123_estado",   db_estado,     4'd5);
    gap(1);
    check("f123_contagem", contagem_quadros, 8'd1);
    check("f123_pulso1",   medida_valida,    1'b0);
    check("f123_volta",    db_estado,        4'd1);
    gap(2);

    // Bad character mid-frame, resync, then "007#".
    send_char("4", 1'b0); gap(2);
    send_char("A", 1'b0);
    check("bad_erro",   erro_quadro, 1'b1);
    check("bad_estado", db_estado,   4'd7);
    gap(1);
    check("bad_sinc",   db_estado,   4'd6);
    gap(1);
    send_char("5", 1'b0); gap(2);
    send_char("#", 1'b0);
    check("resync_estado", db_estado,     4'd1);
    check("resync_valida", medida_valida, 1'b0);
    gap(2);
    send_digits("0", "0", "7");
    send_char("#", 1'b0);
    check("f007_medida", medida, 12'h007);
    gap(1);
    check("f007_contagem", contagem_quadros, 8'd2);
    gap(2);

    // Character with erro_rx in espera_centena.
    send_char("9", 1'b1);
    check("perr_erro", erro_quadro, 1'b1);
    gap(1);
    check("perr_sinc",   db_estado, 4'd6);
    check("perr_medida", medida,    12'h007);
    gap(1);
    send_char("#", 1'b0);
    check("perr_resync", db_estado, 4'd1);
    gap(2);

    // Inter-character timeout after "12".
    send_char("1", 1'b0); gap(2);
    send_char("2", 1'b0);
    gap(99);
    check("to_antes_erro",   erro_quadro, 1'b0);
    check("to_antes_estado", db_estado,   4'd3);
    gap(1);
    check("to_erro",   erro_quadro, 1'b1);
    check("to_estado", db_estado,   4'd8);
    gap(1);
    check("to_volta",  db_estado,   4'd1);
    check("to_pulso1", erro_quadro, 1'b0);
    gap(1);
    send_digits("3", "4", "5");
    send_char("#", 1'b0);
    check("f345_medida", medida, 12'h345);
    gap(3);

    // Stray terminators are not errors.
    send_char("#", 1'b0);
    check("hash1_erro",   erro_quadro, 1'b0);
    check("hash1_estado", db_estado,   4'd1);
    gap(2);
    send_char("#", 1'b0);
    check("hash2_erro",   erro_quadro, 1'b0);
    check("hash2_estado", db_estado,   4'd1);
    gap(2);

    // 255 more frames: count goes 3 -> wraps to 0 after frame 253 -> 2.
    for (int i = 1; i <= 255; i++) begin
      send_frame(byte'(8'h30 + i / 100), byte'(8'h30 + (i / 10) % 10), byte'(8'h30 + i % 10));
      if (i == 253) check("wrap_zero", contagem_quadros, 8'd0);
    end
    check("wrap_final",  contagem_quadros, 8'd2);
    check("wrap_medida", medida,           12'h255);

    // Drop ligar mid-frame.
    send_char("8", 1'b0); gap(2);
    send_char("8", 1'b0);
    ligar = 1'b0;
    gap(1);
    check("off_estado",   db_estado,        4'd0);
    check("off_erro",     erro_quadro,      1'b0);
    check("off_medida",   medida,           12'h255);
    check("off_contagem", contagem_quadros, 8'd2);
    gap(3);
    ligar = 1'b1;
    gap(2);

    // Asynchronous reset mid-frame.
    send_char("1", 1'b0); gap(2);
    send_char("2", 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_medida",   medida,           12'h000);
    check("arst_valida",   medida_valida,    1'b0);
    check("arst_erro",     erro_quadro,      1'b0);
    check("arst_contagem", contagem_quadros, 8'd0);
    check("arst_estado",   db_estado,        4'd0);
    gap(1);
    reset = 1'b0;
    gap(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
